// File: rtl/adaptive_threshold_scheduler.sv
// Adaptive threshold scheduler: staggers filter worker launch and
// round-robin arbitrates their pixel writes into a framebuffer port.
module adaptive_threshold_scheduler #(
   parameter int NUM_PARALLEL = 4,
   parameter int WIDTH_BITS   = 8,
   parameter int HEIGHT_BITS  = 8,
   parameter int C_BITS       = 5,
   parameter int COLOR_BITS   = 3,
   parameter int LAUNCH_GAP   = 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   input  logic [C_BITS-1:0]                 i_c,
   input  logic                              i_invert,
   output logic [NUM_PARALLEL-1:0]           o_enable,
   output logic [C_BITS-1:0]                 o_c,
   input  logic [NUM_PARALLEL-1:0]           i_finished,
   input  logic [NUM_PARALLEL-1:0]           i_req_valid,
   input  logic [NUM_PARALLEL*WIDTH_BITS-1:0]  i_req_x,
   input  logic [NUM_PARALLEL*HEIGHT_BITS-1:0] i_req_y,
   input  logic [NUM_PARALLEL-1:0]           i_req_data,
   output logic [NUM_PARALLEL-1:0]           o_req_ready,
   output logic [WIDTH_BITS-1:0]             o_x,
   output logic [HEIGHT_BITS-1:0]            o_y,
   output logic [COLOR_BITS-1:0]             o_r,
   output logic [COLOR_BITS-1:0]             o_g,
   output logic [COLOR_BITS-1:0]             o_b,
   output logic                              o_wren,
   output logic [1:0]                        o_state,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [31:0]                       o_cycles
);

   localparam int PW = (NUM_PARALLEL > 1) ? $clog2(NUM_PARALLEL) : 1;
   localparam int GW = $clog2(LAUNCH_GAP + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_PARALLEL-1:0] en_q, en_d;
   logic [C_BITS-1:0]       c_q, c_d;
   logic                    inv_q, inv_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [PW-1:0]           idx_q, idx_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic [31:0]             cyc_q, cyc_d;
   logic                    wren_q, wren_d;
   logic [WIDTH_BITS-1:0]   x_q, x_d;
   logic [HEIGHT_BITS-1:0]  y_q, y_d;
   logic [COLOR_BITS-1:0]   col_q, col_d;
   logic                    done_q, done_d;

   logic                    active;
   logic                    launch_adv;
   logic                    launch_fin;
   logic                    run_fin;
   logic                    gnt_vld;
   logic [PW-1:0]           gnt_idx;

   assign launch_adv = (int'(gap_q) == LAUNCH_GAP - 1);
   // Leave LAUNCH on the same edge that raises the last enable.
   assign launch_fin = (int'(idx_q) == NUM_PARALLEL - 1) ||
                       (launch_adv && (int'(idx_q) == NUM_PARALLEL - 2));
   assign run_fin    = (&i_finished) && !(|i_req_valid);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_LAUNCH;
         S_LAUNCH: if (launch_fin) state_d = S_RUN;
         S_RUN:    if (run_fin) state_d = S_DONE;
         S_DONE:   if (!start) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      active      = (state_q == S_LAUNCH) || (state_q == S_RUN);
      o_busy      = active;
      o_state     = state_q;
      o_req_ready = '0;
      if (active && gnt_vld) o_req_ready[gnt_idx] = 1'b1;
   end

   // First valid worker at or after the pointer, wrapping.
   always_comb begin : arb_blk
      int j;
      j       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_PARALLEL; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_PARALLEL) j = j - NUM_PARALLEL;
         if (!gnt_vld && i_req_valid[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(j);
         end
      end
   end

   always_comb begin
      en_d   = en_q;
      c_d    = c_q;
      inv_d  = inv_q;
      ptr_d  = ptr_q;
      idx_d  = idx_q;
      gap_d  = gap_q;
      cyc_d  = cyc_q;
      wren_d = 1'b0;
      x_d    = x_q;
      y_d    = y_q;
      col_d  = col_q;
      done_d = 1'b0;
      if (active && cyc_q != '1) cyc_d = cyc_q + 32'd1;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               c_d   = i_c;
               inv_d = i_invert;
               cyc_d = '0;
               en_d  = '0;
               en_d[0] = 1'b1;
               idx_d = '0;
               gap_d = '0;
            end
         end
         S_LAUNCH: begin
            if (launch_adv) begin
               gap_d = '0;
               if (int'(idx_q) < NUM_PARALLEL - 1) begin
                  idx_d = idx_q + PW'(1);
                  for (int k = 0; k < NUM_PARALLEL; k++)
                     if (k == int'(idx_q) + 1) en_d[k] = 1'b1;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         S_RUN: begin
            if (run_fin) begin
               en_d   = '0;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (active && gnt_vld) begin
         wren_d = 1'b1;
         x_d    = i_req_x[gnt_idx*WIDTH_BITS +: WIDTH_BITS];
         y_d    = i_req_y[gnt_idx*HEIGHT_BITS +: HEIGHT_BITS];
         col_d  = {COLOR_BITS{i_req_data[gnt_idx] ^ inv_q}};
         ptr_d  = (int'(gnt_idx) == NUM_PARALLEL - 1) ? '0 : gnt_idx + PW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_q   <= '0;
         c_q    <= '0;
         inv_q  <= 1'b0;
         ptr_q  <= '0;
         idx_q  <= '0;
         gap_q  <= '0;
         cyc_q  <= '0;
         wren_q <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
         col_q  <= '0;
         done_q <= 1'b0;
      end else begin
         en_q   <= en_d;
         c_q    <= c_d;
         inv_q  <= inv_d;
         ptr_q  <= ptr_d;
         idx_q  <= idx_d;
         gap_q  <= gap_d;
         cyc_q  <= cyc_d;
         wren_q <= wren_d;
         x_q    <= x_d;
         y_q    <= y_d;
         col_q  <= col_d;
         done_q <= done_d;
      end
   end

   assign o_enable = en_q;
   assign o_c      = c_q;
   assign o_x      = x_q;
   assign o_y      = y_q;
   assign o_r      = col_q;
   assign o_g      = col_q;
   assign o_b      = col_q;
   assign o_wren   = wren_q;
   assign o_done   = done_q;
   assign o_cycles = cyc_q;

endmodule
